// File: rtl/uart_rx_controller.sv
// uart_rx_controller
//   UART receive sequencer. Synchronises the raw rx line, detects the falling
//   start edge, times mid-bit sampling with a down-counter, deserialises an
//   LSB-first frame, checks the stop bit and hands good bytes to a one-entry
//   valid/ready holding buffer. Keeps 12-bit wrapping frame/error counters.
//
// Ports
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   rx             raw asynchronous UART line (idle high)
//   byte_data      received byte, held while byte_valid is 1
//   byte_valid     byte_data holds an unconsumed byte
//   byte_ready     consumer accepts byte_data when byte_valid & byte_ready
//   busy           frame in progress
//   framing_error  1-cycle pulse: stop bit sampled 0
//   overrun        1-cycle pulse: good frame dropped, buffer full
//   frame_count    good frames received (wraps)
//   error_count    framing errors plus overruns (wraps)

module uart_rx_controller #(
  parameter int clocks_per_bit = 434,
  parameter int data_width     = 8,
  parameter int sync_stages    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rx,
  output logic [data_width-1:0] byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  framing_error,
  output logic                  overrun,
  output logic [11:0]           frame_count,
  output logic [11:0]           error_count
);

  localparam int CW = $clog2(clocks_per_bit);
  localparam int IW = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(clocks_per_bit / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(clocks_per_bit - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(data_width - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state;
  logic [sync_stages-1:0] sync_reg;
  logic                   prev_reg;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          bit_idx;
  logic [data_width-1:0]  shift_reg;

  logic rxs;
  logic start_edge;
  logic sample;
  logic accept;

  assign rxs        = sync_reg[sync_stages-1];
  assign start_edge = prev_reg & ~rxs;
  assign sample     = (cnt == '0);
  assign accept     = byte_valid & byte_ready;
  // state is itself a register, so busy carries no combinational path from rx.
  assign busy       = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // Synchroniser and edge history reset to the idle (high) level so that
      // leaving reset never looks like a start edge.
      sync_reg      <= '1;
      prev_reg      <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      byte_data     <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      frame_count   <= '0;
      error_count   <= '0;
    end else begin
      sync_reg      <= {sync_reg[sync_stages-2:0], rx};
      prev_reg      <= rxs;
      framing_error <= 1'b0;
      overrun       <= 1'b0;

      // A delivery later in this block overrides this clear.
      if (accept) begin
        byte_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Only the 1->0 transition starts a frame; a held-low line is ignored.
          if (start_edge) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end

        START: begin
          if (sample) begin
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= '0;
              cnt     <= FULL_LOAD;
            end else begin
              state <= IDLE;   // glitch shorter than half a bit
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        DATA: begin
          if (sample) begin
            // Shift right so that after data_width samples bit k sits at k.
            shift_reg <= {rxs, shift_reg[data_width-1:1]};
            cnt       <= FULL_LOAD;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        STOP: begin
          if (sample) begin
            state <= IDLE;
            if (rxs) begin
              frame_count <= frame_count + 12'd1;
              if (!byte_valid || byte_ready) begin
                byte_data  <= shift_reg;
                byte_valid <= 1'b1;
              end else begin
                overrun     <= 1'b1;
                error_count <= error_count + 12'd1;
              end
            end else begin
              framing_error <= 1'b1;
              error_count   <= error_count + 12'd1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- Full UART receive sequencer for the DE0-CV UART path: synchronises the raw rx line, detects a start edge, times mid-bit sampling, deserialises an LSB-first frame and checks the stop bit.
- Sits between the GPIO rx pin and user logic.
- Presents received bytes through a one-entry valid/ready holding buffer.
- Provides 12-bit frame and error counters sized for the six-digit hex display.

Parameters:
- clocks_per_bit, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 4.
- data_width, 8, data bits per frame; 1..8.
- sync_stages, 2, rx synchroniser depth; ≥ 2.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- rx  input  1  raw asynchronous UART line; idle high.
- byte_data  output  data_width  received byte, held while byte_valid is 1.
- byte_valid  output  1  byte_data holds an unconsumed byte.
- byte_ready  input  1  consumer accepts byte_data when byte_valid and byte_ready are both 1.
- busy  output  1  frame in progress (state ≠ IDLE).
- framing_error  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: good frame discarded because the buffer was full.
- frame_count  output  12  good frames received; wraps 4095→0.
- error_count  output  12  framing errors plus overruns; wraps 4095→0.

Behaviour:
- Reset (async, reset_n=0):
  - Synchroniser flops and the edge-history flop go to 1.
  - State goes to IDLE; counters and the shift register clear.
  - byte_data=0, byte_valid=0, busy=0, framing_error=0, overrun=0, frame_count=0, error_count=0.
  - Reset mid-frame abandons the frame with no pulses.
- rxs is rx delayed by sync_stages flops. A start edge is rxs=0 while the previous rxs=1.
- The FSM has four states: IDLE, START, DATA, STOP. A down-counter is loaded as stated per state; a "sample" occurs in the cycle the counter reaches 0.
  - IDLE: on a start edge at cycle T, go to START and load clocks_per_bit/2 − 1 (integer division). Any non-edge rxs=0 is ignored, so a held-low/break line never re-triggers.
  - START: sample at T + clocks_per_bit/2.
    - rxs=0: go to DATA, bit index 0, load clocks_per_bit − 1.
    - rxs=1: glitch; return to IDLE with no pulses.
  - DATA: a sample occurs every clocks_per_bit cycles. Shift rxs in LSB-first (bit k lands in position k) and reload the counter.
    - After sample data_width−1, go to STOP and load clocks_per_bit − 1.
  - STOP: sample at T + clocks_per_bit/2 + (data_width+1)·clocks_per_bit.
    - rxs=1 (good frame): frame_count+1 and deliver to the buffer.
    - rxs=0: framing_error pulses for 1 cycle, error_count+1, data discarded.
    - Either way, go to IDLE in the next cycle.
- busy is high from the cycle after the start edge through the STOP sample cycle.
- Holding buffer:
  - Delivery is registered: byte_data and byte_valid update in the cycle after the STOP sample.
  - Accept (byte_valid & byte_ready) clears byte_valid next cycle unless a delivery coincides.
  - Delivery while byte_valid=0, or while an accept occurs in the same cycle: load byte_data and set byte_valid=1.
  - Delivery while byte_valid=1 with no accept: keep the old byte; overrun pulses 1 cycle; error_count+1. frame_count still increments.
  - byte_data is unchanged while byte_valid=0 after an accept (last value retained).
- Counters saturate never; they wrap. If framing_error and overrun coincide, error_count adds 1 per event; structurally they are mutually exclusive.
- A new start edge can be detected the cycle after returning to IDLE, so back-to-back frames with a one-bit stop are supported.

Test Plan (clocks_per_bit=16, data_width=8, sync_stages=2, frames driven at exactly 16 cycles/bit):
- Frame 0xA5, byte_ready=1 → byte_valid high for exactly 1 cycle with byte_data=0xA5; frame_count=1; error_count=0; busy low after STOP.
- rx low for 5 cycles then high → START sample sees 1; busy drops; no byte_valid, no pulses; counts unchanged.
- Frame 0x3C with stop bit 0, then rx held low 300 cycles → one framing_error pulse; error_count=1; no byte_valid; no further activity until rx goes high and falls again.
- byte_ready=0; frames 0x11 then 0x22 → byte_data stays 0x11; overrun pulses once; frame_count=2; error_count=1; then byte_ready=1 → 0x11 accepted and byte_valid drops.
- Back-to-back frames 0x00 and 0xFF with no idle gap, byte_ready=1 → both delivered in order; frame_count=2.
- reset_n pulsed low during DATA bit 3 → all outputs 0 immediately; next frame 0x5A received correctly; frame_count=1.
